// File: rtl/score_pkg.sv
// ----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the scoreboard score keeper: FSM state encoding,
// BCD digit constants and a helper that widens a BCD nibble to the digit
// code width consumed by the 7-segment multiplexer.
// ----------------------------------------------------------------------------
package score_pkg;

  // FSM states. The encoding is chosen so that bit 0 is "running" and
  // bit 1 is "game over", letting both flags come straight off the state
  // flops with no decode.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int         DIGIT_W       = 5;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Four-digit saturation value, 9999 in packed BCD.
  localparam logic [15:0] BCD_SAT = 16'h9999;

  // Digit code for the display mux: value 0..9 with the top bit clear.
  function automatic logic [DIGIT_W-1:0] to_digit(input logic [3:0] d);
    return DIGIT_W'(d);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// ----------------------------------------------------------------------------
// bcd_digit_add
// One-digit BCD adder with carry in/out, chained four times by the score
// counter.
//   a, b  in  4  BCD operands (0..9)
//   cin   in  1  carry from the next lower digit
//   sum   out 4  BCD result digit (0..9)
//   cout  out 1  carry to the next higher digit
// ----------------------------------------------------------------------------
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  // NOTE: every output of an always_comb block is assigned on every path;
  // a path that leaves one untouched would infer a latch.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      // Adding 6 skips the six unused nibble codes; max raw 19 -> 9 carry 1.
      sum  = 4'(raw + 5'd6);
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_bcd_counter.sv
// ----------------------------------------------------------------------------
// score_bcd_counter
// Run-time score keeper feeding the 7-segment digit multiplexer. Tracks the
// game phase (IDLE / RUN / OVER) and accumulates a saturating 4-digit BCD
// score from a distance prescaler and coin pickups.
//
// Parameters
//   SCORE_DIV   clock cycles per distance point while running (2..2^26)
//   COIN_VALUE  points per coin pickup (0..99)
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      pulse: begin a new run (IDLE or OVER only)
//   coin_tick                  pulse: coin collected (counted in RUN only)
//   collision                  level/pulse: player died (RUN -> OVER)
//   digit0..digit3             score digit codes, digit0 = ones
//   hi_digit0..hi_digit3       high-score digit codes
//   gameover, running          phase flags
// Build option
//   SCORE_HISCORE_EN           when defined, keeps a high score updated on
//                              each RUN -> OVER transition; otherwise the
//                              hi digits are constant zero.
// ----------------------------------------------------------------------------
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int SCORE_DIV  = 25_000_000,
  parameter int COIN_VALUE = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               coin_tick,
  input  logic               collision,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit3,
  output logic [DIGIT_W-1:0] hi_digit0,
  output logic [DIGIT_W-1:0] hi_digit1,
  output logic [DIGIT_W-1:0] hi_digit2,
  output logic [DIGIT_W-1:0] hi_digit3,
  output logic               gameover,
  output logic               running
);

  localparam int              PS_W      = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(SCORE_DIV - 1);
  localparam logic [3:0]      COIN_TENS = 4'(COIN_VALUE / 10);
  localparam logic [3:0]      COIN_ONES = 4'(COIN_VALUE % 10);

  logic [1:0]      state;
  logic [PS_W-1:0] ps_cnt;
  logic [15:0]     score;

  logic            point;
  logic [15:0]     addend;
  logic [15:0]     sum_bcd;
  logic [4:0]      carry;
  logic [15:0]     score_next;

  assign point = (state == ST_RUN) && (ps_cnt == PS_LAST);

  // The distance point enters as the carry into the ones digit, so a coin
  // whose ones digit is 9 plus a point still resolves through normal carry.
  assign addend   = coin_tick ? {8'h00, COIN_TENS, COIN_ONES} : 16'h0000;
  assign carry[0] = point;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_add u_add (
      .a    (score[4*i +: 4]),
      .b    (addend[4*i +: 4]),
      .cin  (carry[i]),
      .sum  (sum_bcd[4*i +: 4]),
      .cout (carry[i+1])
    );
  end

  // Carry out of the thousands digit means the true sum passed 9999.
  assign score_next = carry[4] ? BCD_SAT : sum_bcd;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ps_cnt <= '0;
      score  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state  <= ST_RUN;
            ps_cnt <= '0;
            score  <= '0;
          end
        end
        ST_RUN: begin
          if (collision) begin
            // Increments arriving with the collision are dropped.
            state <= ST_OVER;
          end else begin
            score  <= score_next;
            ps_cnt <= point ? '0 : ps_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign running  = state[0];
  assign gameover = state[1];

  assign digit0 = to_digit(score[3:0]);
  assign digit1 = to_digit(score[7:4]);
  assign digit2 = to_digit(score[11:8]);
  assign digit3 = to_digit(score[15:12]);

  logic [15:0] hi_score;

`ifdef SCORE_HISCORE_EN
  // Packed BCD orders the same as binary, so a plain unsigned compare works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_score <= '0;
    end else if ((state == ST_RUN) && collision && (score > hi_score)) begin
      hi_score <= score;
    end
  end
`else
  assign hi_score = 16'h0000;
`endif

  assign hi_digit0 = to_digit(hi_score[3:0]);
  assign hi_digit1 = to_digit(hi_score[7:4]);
  assign hi_digit2 = to_digit(hi_score[11:8]);
  assign hi_digit3 = to_digit(hi_score[15:12]);

endmodule

// File: tb/tb_score_bcd_counter.sv
// ----------------------------------------------------------------------------
// tb_score_bcd_counter
// Directed bench for score_bcd_counter with SCORE_DIV=4, COIN_VALUE=10.
// Time is counted in edges E0.. from each start pulse; distance points land
// on edges that are multiples of 4. Inputs change and outputs are sampled
// 1 time unit after a rising edge.
// ----------------------------------------------------------------------------
module tb_score_bcd_counter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       coin_tick;
  logic       collision;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic [4:0] hi_digit0, hi_digit1, hi_digit2, hi_digit3;
  logic       gameover;
  logic       running;

  int n_vec = 0;
  int n_bad = 0;

  score_bcd_counter #(
    .SCORE_DIV  (4),
    .COIN_VALUE (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .coin_tick (coin_tick),
    .collision (collision),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .hi_digit0 (hi_digit0),
    .hi_digit1 (hi_digit1),
    .hi_digit2 (hi_digit2),
    .hi_digit3 (hi_digit3),
    .gameover  (gameover),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] score_w;
  logic [19:0] hi_w;
  assign score_w = {digit3, digit2, digit1, digit0};
  assign hi_w    = {hi_digit3, hi_digit2, hi_digit1, hi_digit0};

  // Expected 4 x 5-bit digit codes from a packed BCD constant.
  function automatic logic [19:0] dig(input logic [15:0] b);
    return {1'b0, b[15:12], 1'b0, b[11:8], 1'b0, b[7:4], 1'b0, b[3:0]};
  endfunction

  function automatic logic [19:0] hi_exp(input logic [15:0] b);
`ifdef SCORE_HISCORE_EN
    return dig(b);
`else
    return dig(16'h0000) | (b & 16'h0000);
`endif
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    coin_tick = 1'b0;
    collision = 1'b0;
    step(3);
    check("rst_score",    score_w,           dig(16'h0000));
    check("rst_hi",       hi_w,              dig(16'h0000));
    check("rst_gameover", {19'b0, gameover}, 20'd0);
    check("rst_running",  {19'b0, running},  20'd0);
    rst_n = 1'b1;
    step(2);

    // Coin in IDLE is ignored.
    coin_tick = 1'b1; step(1); coin_tick = 1'b0;
    check("idle_coin",    score_w,           dig(16'h0000));
    check("idle_running", {19'b0, running},  20'd0);

    // Run 1: ends at 0042 with a coin and a point in the collision cycle.
    pulse_start();                                        // E0
    check("a_running",  {19'b0, running},  20'd1);
    check("a_gameover", {19'b0, gameover}, 20'd0);
    check("a_clear",    score_w,           dig(16'h0000));
    step(4);                                              // E4
    check("a_first_pt", score_w, dig(16'h0001));
    step(36);                                             // E40
    check("a_40cyc",    score_w, dig(16'h0010));
    pulse_start();                                        // E41
    check("a_start_ign", score_w, dig(16'h0010));
    coin_tick = 1'b1; step(2); coin_tick = 1'b0;          // E43: 30
    step(1);                                              // E44: 31
    coin_tick = 1'b1; step(1); coin_tick = 1'b0;          // E45: 41
    step(3);                                              // E48: 42
    check("a_0042", score_w, dig(16'h0042));
    step(3);                                              // E51
    coin_tick = 1'b1; collision = 1'b1; step(1);          // E52
    coin_tick = 1'b0; collision = 1'b0;
    check("a_over",      {19'b0, gameover}, 20'd1);
    check("a_not_run",   {19'b0, running},  20'd0);
    check("a_discard",   score_w,           dig(16'h0042));
    check("a_hi",        hi_w,              hi_exp(16'h0042));
    coin_tick = 1'b1; collision = 1'b1; step(8);
    coin_tick = 1'b0; collision = 1'b0;
    check("a_frozen",    score_w,           dig(16'h0042));
    check("a_over_hold", {19'b0, gameover}, 20'd1);

    // Run 2: ends at 0017, high score unchanged.
    pulse_start();
    check("b_clear",    score_w,           dig(16'h0000));
    check("b_running",  {19'b0, running},  20'd1);
    check("b_gameover", {19'b0, gameover}, 20'd0);
    step(68);
    check("b_0017", score_w, dig(16'h0017));
    collision = 1'b1; step(1); collision = 1'b0;
    check("b_final", score_w, dig(16'h0017));
    check("b_hi",    hi_w,    hi_exp(16'h0042));

    // Run 3: coin coincident with a point at 0009, then ends at 0100.
    pulse_start();                                        // E0
    step(36);                                             // E36
    check("c_0009", score_w, dig(16'h0009));
    step(3);                                              // E39
    coin_tick = 1'b1; step(1); coin_tick = 1'b0;          // E40
    check("c_coin_pt", score_w, dig(16'h0020));
    coin_tick = 1'b1; step(6); coin_tick = 1'b0;          // E46
    check("c_0081", score_w, dig(16'h0081));
    step(74);                                             // E120
    check("c_0100", score_w, dig(16'h0100));
    collision = 1'b1; step(1); collision = 1'b0;
    check("c_hi", hi_w, hi_exp(16'h0100));

    // Run 4: saturation at 9999.
    pulse_start();                                        // E0
    coin_tick = 1'b1; step(974); coin_tick = 1'b0;        // E974
    check("d_9983", score_w, dig(16'h9983));
    step(46);                                             // E1020
    check("d_9995", score_w, dig(16'h9995));
    coin_tick = 1'b1; step(1); coin_tick = 1'b0;          // E1021
    check("d_sat_coin", score_w, dig(16'h9999));
    step(3);                                              // E1024
    check("d_sat_pt",   score_w, dig(16'h9999));
    collision = 1'b1; step(1); collision = 1'b0;
    check("d_hi", hi_w, hi_exp(16'h9999));

    // Run 5: asynchronous reset mid-run at 0123.
    pulse_start();                                        // E0
    coin_tick = 1'b1; step(11); coin_tick = 1'b0;         // E11: 112
    step(1);                                              // E12: 113
    coin_tick = 1'b1; step(1); coin_tick = 1'b0;          // E13: 123
    check("e_0123", score_w, dig(16'h0123));
    rst_n = 1'b0;
    #1;
    check("e_rst_score",    score_w,           dig(16'h0000));
    check("e_rst_hi",       hi_w,              dig(16'h0000));
    check("e_rst_gameover", {19'b0, gameover}, 20'd0);
    check("e_rst_running",  {19'b0, running},  20'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    pulse_start();
    check("e_restart",  score_w,          dig(16'h0000));
    check("e_running",  {19'b0, running}, 20'd1);
    step(4);
    check("e_first_pt", score_w,          dig(16'h0001));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
